tmnt_video_timing: RTL and testbench

Generates the 6 MHz pixel timing for the TMNT board from the 24 MHz main clock: pixel divider, horizontal/vertical counters, blanking and sync, the vblank interrupt to the 68000, and the 051550-style watchdog. It sits upstream of the tile/sprite chips and the colour stage, driving their V6M and NCBLK. It also drives the CPU's IPL lines (OIPL) and consumes INT16EN, AFR and the interrupt-acknowledge cycle from the CPU address decode.

---
 rtl/tmnt_timing_pkg.sv | 24 ++
 rtl/tmnt_watchdog.sv | 58 +++++
 rtl/tmnt_video_timing.sv | 122 ++++++++++++
 tb/tb_tmnt_video_timing.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmnt_timing_pkg.sv
// Shared TMNT video/watchdog timing constants, reused by the tile and sprite chip models.
package tmnt_timing_pkg;

    localparam int unsigned TMNT_CNT_W       = 9;
    localparam int unsigned TMNT_H_TOTAL     = 384;
    localparam int unsigned TMNT_H_VIS       = 320;
    localparam int unsigned TMNT_HS_START    = 336;
    localparam int unsigned TMNT_HS_LEN      = 32;
    localparam int unsigned TMNT_V_TOTAL     = 264;
    localparam int unsigned TMNT_V_VIS_START = 16;
    localparam int unsigned TMNT_V_VIS_END   = 240;
    localparam int unsigned TMNT_VS_START    = 248;
    localparam int unsigned TMNT_VS_LEN      = 8;
    localparam int unsigned TMNT_WDT_FRAMES  = 8;
    localparam int unsigned TMNT_WDT_PULSE   = 16;

    // True when x lies in the half-open window [lo, lo+len).
    function automatic logic in_window(input logic [TMNT_CNT_W-1:0] x,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (32'(x) >= lo) && (32'(x) < lo + len);
    endfunction

endpackage

// File: rtl/tmnt_watchdog.sv
// 051550-style watchdog: AFR falling-edge kick, vblank frame counter, fixed-width reset pulse.
module tmnt_watchdog
    import tmnt_timing_pkg::*;
#(
    parameter int unsigned WDT_FRAMES = TMNT_WDT_FRAMES,
    parameter int unsigned WDT_PULSE  = TMNT_WDT_PULSE
) (
    input  logic clk_main,
    input  logic reset,
    input  logic afr_n,
    input  logic vblank_evt,
    output logic wdt_reset
);

    localparam int unsigned PULSE_W = $clog2(WDT_PULSE + 1);

    logic               afr_q;
    logic [3:0]         frame_cnt;
    logic [PULSE_W-1:0] pulse_cnt;
    logic               kick_c;
    logic               expire_c;

    // A kick on the terminal vblank cycle wins, so no pulse is started.
    always_comb begin
        kick_c   = afr_q & ~afr_n;
        expire_c = !kick_c && vblank_evt && (frame_cnt == 4'(WDT_FRAMES - 1));
    end

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            afr_q     <= 1'b1;
            frame_cnt <= '0;
        end else begin
            afr_q <= afr_n;
            if (kick_c || expire_c) begin
                frame_cnt <= '0;
            end else if (vblank_evt) begin
                frame_cnt <= frame_cnt + 4'd1;
            end
        end
    end

    // Pulse stretcher; kicks during the pulse do not affect it.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            pulse_cnt <= '0;
            wdt_reset <= 1'b0;
        end else if (expire_c) begin
            pulse_cnt <= PULSE_W'(WDT_PULSE - 1);
            wdt_reset <= 1'b1;
        end else if (pulse_cnt != '0) begin
            pulse_cnt <= pulse_cnt - PULSE_W'(1);
        end else begin
            wdt_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/tmnt_video_timing.sv
// TMNT 6 MHz pixel timing: divider, h/v counters, blank/sync decodes, vblank IRQ and watchdog.
module tmnt_video_timing
    import tmnt_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL     = TMNT_H_TOTAL,
    parameter int unsigned H_VIS       = TMNT_H_VIS,
    parameter int unsigned HS_START    = TMNT_HS_START,
    parameter int unsigned HS_LEN      = TMNT_HS_LEN,
    parameter int unsigned V_TOTAL     = TMNT_V_TOTAL,
    parameter int unsigned V_VIS_START = TMNT_V_VIS_START,
    parameter int unsigned V_VIS_END   = TMNT_V_VIS_END,
    parameter int unsigned VS_START    = TMNT_VS_START,
    parameter int unsigned VS_LEN      = TMNT_VS_LEN,
    parameter int unsigned WDT_FRAMES  = TMNT_WDT_FRAMES,
    parameter int unsigned WDT_PULSE   = TMNT_WDT_PULSE
) (
    input  logic       clk_main,
    input  logic       reset,
    input  logic       int16en,
    input  logic       iack,
    input  logic       afr_n,
    output logic       v6m,
    output logic       ce_6m,
    output logic [8:0] hcount,
    output logic [8:0] vcount,
    output logic       nhblk,
    output logic       nvblk,
    output logic       ncblk,
    output logic       nhsync,
    output logic       nvsync,
    output logic       video_sync,
    output logic       oipl,
    output logic       wdt_reset
);

    logic [1:0] div;
    logic [1:0] div_nxt;
    logic       h_wrap;
    logic       v_wrap;
    logic [8:0] h_nxt;
    logic [8:0] v_nxt;
    logic       nhblk_nxt;
    logic       nvblk_nxt;
    logic       nhsync_nxt;
    logic       nvsync_nxt;
    logic       vblank_evt_c;

    // Decodes are taken from the next counter values so they land with the counters.
    always_comb begin
        div_nxt      = div + 2'd1;
        h_wrap       = (hcount == 9'(H_TOTAL - 1));
        v_wrap       = (vcount == 9'(V_TOTAL - 1));
        h_nxt        = h_wrap ? 9'd0 : hcount + 9'd1;
        v_nxt        = vcount;
        if (h_wrap) begin
            v_nxt = v_wrap ? 9'd0 : vcount + 9'd1;
        end
        nhblk_nxt    = (32'(h_nxt) < H_VIS);
        nvblk_nxt    = (32'(v_nxt) >= V_VIS_START) && (32'(v_nxt) < V_VIS_END);
        nhsync_nxt   = !in_window(h_nxt, HS_START, HS_LEN);
        nvsync_nxt   = !in_window(v_nxt, VS_START, VS_LEN);
        vblank_evt_c = ce_6m && h_wrap && (vcount == 9'(V_VIS_END - 1));
    end

    // Pixel divider; ce_6m and v6m are registered copies of div==3 and div[1].
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            div   <= 2'd0;
            ce_6m <= 1'b0;
            v6m   <= 1'b0;
        end else begin
            div   <= div_nxt;
            ce_6m <= (div_nxt == 2'd3);
            v6m   <= div_nxt[1];
        end
    end

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            hcount     <= 9'd0;
            vcount     <= 9'd0;
            nhblk      <= 1'b1;
            nvblk      <= 1'b0;
            ncblk      <= 1'b0;
            nhsync     <= 1'b1;
            nvsync     <= 1'b1;
            video_sync <= 1'b1;
        end else if (ce_6m) begin
            hcount     <= h_nxt;
            vcount     <= v_nxt;
            nhblk      <= nhblk_nxt;
            nvblk      <= nvblk_nxt;
            ncblk      <= nhblk_nxt & nvblk_nxt;
            nhsync     <= nhsync_nxt;
            nvsync     <= nvsync_nxt;
            video_sync <= ~(nhsync_nxt ^ nvsync_nxt);
        end
    end

    // Active-low IRQ request; a new vblank beats a coincident acknowledge.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            oipl <= 1'b1;
        end else if (vblank_evt_c && int16en) begin
            oipl <= 1'b0;
        end else if (!int16en || iack) begin
            oipl <= 1'b1;
        end
    end

    tmnt_watchdog #(
        .WDT_FRAMES (WDT_FRAMES),
        .WDT_PULSE  (WDT_PULSE)
    ) u_watchdog (
        .clk_main   (clk_main),
        .reset      (reset),
        .afr_n      (afr_n),
        .vblank_evt (vblank_evt_c),
        .wdt_reset  (wdt_reset)
    );

endmodule

// File: tb/tb_tmnt_video_timing.sv
// Bench for tmnt_video_timing on a shrunken raster, checked against an arithmetic reference model.
module tb_tmnt_video_timing;

    localparam int HT = 16, HV = 10, HSS = 11, HSL = 3;
    localparam int VT = 14, VVS = 2, VVE = 10, VSS = 11, VSL = 2;
    localparam int WF = 8, WP = 16;
    localparam int FRAME = HT * VT;
    localparam logic [27:0] RST_VAL = {1'b0, 1'b0, 9'd0, 9'd0, 1'b1, 1'b0, 1'b0,
                                       1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    logic clk_main = 1'b0;
    logic reset    = 1'b1;
    logic int16en  = 1'b0;
    logic iack     = 1'b0;
    logic afr_n    = 1'b1;
    logic v6m, ce_6m, nhblk, nvblk, ncblk, nhsync, nvsync, video_sync, oipl, wdt_reset;
    logic [8:0] hcount, vcount;

    int checks = 0;
    int errors = 0;

    longint m_n;
    int     m_wf;
    int     m_pulse;
    bit     m_flag;
    bit     m_afr_prev;

    initial forever #5 clk_main = ~clk_main;

    tmnt_video_timing #(
        .H_TOTAL(HT), .H_VIS(HV), .HS_START(HSS), .HS_LEN(HSL),
        .V_TOTAL(VT), .V_VIS_START(VVS), .V_VIS_END(VVE), .VS_START(VSS), .VS_LEN(VSL),
        .WDT_FRAMES(WF), .WDT_PULSE(WP)
    ) dut (
        .clk_main(clk_main), .reset(reset), .int16en(int16en), .iack(iack), .afr_n(afr_n),
        .v6m(v6m), .ce_6m(ce_6m), .hcount(hcount), .vcount(vcount),
        .nhblk(nhblk), .nvblk(nvblk), .ncblk(ncblk), .nhsync(nhsync), .nvsync(nvsync),
        .video_sync(video_sync), .oipl(oipl), .wdt_reset(wdt_reset)
    );

    // Edge e is a vblank event when it moves the pixel index onto line VVE, pixel 0.
    function automatic bit is_evt(longint e);
        return (e % 4 == 0) && ((e / 4) % FRAME == VVE * HT);
    endfunction

    function automatic int exp_h(longint n);
        return int'((n / 4) % HT);
    endfunction

    function automatic int exp_v(longint n);
        return int'(((n / 4) / HT) % VT);
    endfunction

    // Reference model: m_n counts clk_main edges since reset release.
    always @(posedge clk_main or posedge reset) begin
        if (reset) begin
            m_n        <= 0;
            m_flag     <= 1'b0;
            m_wf       <= 0;
            m_pulse    <= 0;
            m_afr_prev <= 1'b1;
        end else begin
            m_n        <= m_n + 1;
            m_afr_prev <= afr_n;
            if (is_evt(m_n + 1) && int16en) m_flag <= 1'b1;
            else if (!int16en || iack)      m_flag <= 1'b0;
            if (m_afr_prev && !afr_n)       m_wf <= 0;
            else if (is_evt(m_n + 1))       m_wf <= (m_wf + 1 == WF) ? 0 : m_wf + 1;
            if (!(m_afr_prev && !afr_n) && is_evt(m_n + 1) && m_wf + 1 == WF) m_pulse <= WP;
            else if (m_pulse > 0)           m_pulse <= m_pulse - 1;
        end
    end

    // Steps negedges until the next posedge is a vblank event edge.
    task automatic step_until_evt_next(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < FRAME * 4 + 8; i++) begin
            if (is_evt(m_n + 1)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_main);
        end
    endtask

    task automatic kick();
        afr_n = 1'b0;
        @(negedge clk_main);
        afr_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [27:0] got;
        reset = 1'b1;
        repeat (2) @(negedge clk_main);
        got = {v6m, ce_6m, hcount, vcount, nhblk, nvblk, ncblk, nhsync, nvsync,
               video_sync, oipl, wdt_reset};
        checks++;
        if (got !== RST_VAL) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, RST_VAL);
        end
    endtask

    task automatic test_release();
        int ce_cnt = 0;
        reset = 1'b0;
        for (int i = 0; i < 4 * HT; i++) begin
            if (ce_6m) ce_cnt++;
            @(negedge clk_main);
        end
        checks++;
        if (ce_cnt != HT) begin
            errors++;
            $display("FAIL release_ce_count: got %0d expected %0d", ce_cnt, HT);
        end
        checks++;
        if (hcount !== 9'd0 || vcount !== 9'd1) begin
            errors++;
            $display("FAIL release_wrap: got h=%0d v=%0d expected h=0 v=1", hcount, vcount);
        end
    endtask

    task automatic test_decode();
        logic [25:0] got, exp;
        int h, v;
        bit hb, vb, hs, vs;
        for (int i = 0; i < FRAME * 4 + 8; i++) begin
            h  = exp_h(m_n);
            v  = exp_v(m_n);
            hb = (h < HV);
            vb = (v >= VVS) && (v < VVE);
            hs = !((h >= HSS) && (h < HSS + HSL));
            vs = !((v >= VSS) && (v < VSS + VSL));
            exp = {9'(h), 9'(v), hb, vb, hb & vb, hs, vs, ~(hs ^ vs),
                   (m_n % 4 >= 2), (m_n % 4 == 3)};
            got = {hcount, vcount, nhblk, nvblk, ncblk, nhsync, nvsync, video_sync, v6m, ce_6m};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL decode at h=%0d v=%0d: got %h expected %h", h, v, got, exp);
            end
            @(negedge clk_main);
        end
    endtask

    task automatic test_irq();
        bit ok;
        int16en = 1'b1;
        step_until_evt_next(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL irq_wait: got timeout expected event"); end
        @(negedge clk_main);
        checks++;
        if (oipl !== 1'b0 || vcount !== 9'(VVE) || hcount !== 9'd0) begin
            errors++;
            $display("FAIL irq_set: got oipl=%b v=%0d h=%0d expected oipl=0 v=%0d h=0",
                     oipl, vcount, hcount, VVE);
        end
        repeat (5) @(negedge clk_main);
        iack = 1'b1;
        @(negedge clk_main);
        iack = 1'b0;
        checks++;
        if (oipl !== 1'b1) begin errors++; $display("FAIL irq_iack_clear: got %b expected 1", oipl); end
        step_until_evt_next(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL irq_wait2: got timeout expected event"); end
        int16en = 1'b0;
        @(negedge clk_main);
        checks++;
        if (oipl !== 1'b1) begin errors++; $display("FAIL irq_disabled_evt: got %b expected 1", oipl); end
        for (int i = 0; i < 100; i++) begin
            int16en = 1'($urandom_range(0, 1));
            @(negedge clk_main);
            checks++;
            if (oipl !== 1'b1) begin
                errors++;
                $display("FAIL irq_toggle_no_set: got %b expected 1", oipl);
            end
        end
        int16en = 1'b0;
    endtask

    task automatic test_irq_collision();
        bit ok;
        int16en = 1'b1;
        iack    = 1'b1;
        step_until_evt_next(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL coll_wait: got timeout expected event"); end
        @(negedge clk_main);
        checks++;
        if (oipl !== 1'b0) begin errors++; $display("FAIL irq_collision_set: got %b expected 0", oipl); end
        @(negedge clk_main);
        checks++;
        if (oipl !== 1'b1) begin errors++; $display("FAIL irq_collision_clear: got %b expected 1", oipl); end
        iack = 1'b0;
        @(negedge clk_main);
        int16en = 1'b0;
        @(negedge clk_main);
    endtask

    task automatic test_random();
        for (int i = 0; i < FRAME * 4 * 4; i++) begin
            checks++;
            if (oipl !== ~m_flag || wdt_reset !== (m_pulse > 0)) begin
                errors++;
                $display("FAIL random_ctrl n=%0d: got oipl=%b wdt=%b expected oipl=%b wdt=%b",
                         m_n, oipl, wdt_reset, ~m_flag, (m_pulse > 0));
            end
            int16en = ($urandom_range(0, 7) != 0);
            iack    = ($urandom_range(0, 15) == 0);
            afr_n   = ($urandom_range(0, 255) != 0);
            @(negedge clk_main);
        end
        int16en = 1'b0;
        iack    = 1'b0;
        afr_n   = 1'b1;
        @(negedge clk_main);
    endtask

    task automatic test_watchdog();
        int evts = 0, high = 0, rise_evts = -1;
        bit prev = 1'b0, rise_on_evt = 1'b0;
        kick();
        for (int i = 0; i < 9 * FRAME * 4; i++) begin
            @(negedge clk_main);
            if (is_evt(m_n)) evts++;
            if (wdt_reset && !prev) begin
                rise_evts   = evts;
                rise_on_evt = is_evt(m_n);
            end
            if (wdt_reset) high++;
            prev = wdt_reset;
            checks++;
            if (wdt_reset !== (m_pulse > 0)) begin
                errors++;
                $display("FAIL wdt_model n=%0d: got %b expected %b", m_n, wdt_reset, (m_pulse > 0));
            end
        end
        checks++;
        if (high != WP) begin errors++; $display("FAIL wdt_width: got %0d expected %0d", high, WP); end
        checks++;
        if (rise_evts != WF || !rise_on_evt) begin
            errors++;
            $display("FAIL wdt_rise: got vblanks=%0d on_evt=%b expected vblanks=%0d on_evt=1",
                     rise_evts, rise_on_evt, WF);
        end
    endtask

    task automatic test_kick_every7();
        int since = 0, total = 0, high = 0;
        kick();
        for (int i = 0; i < 20 * FRAME * 4; i++) begin
            @(negedge clk_main);
            if (wdt_reset) high++;
            if (is_evt(m_n)) begin
                since++;
                total++;
                if (since == 7) begin
                    kick();
                    if (wdt_reset) high++;
                    since = 0;
                end
            end
        end
        checks++;
        if (high != 0 || total < 16) begin
            errors++;
            $display("FAIL wdt_kick7: got high=%0d vblanks=%0d expected high=0 vblanks>=16", high, total);
        end
    endtask

    task automatic test_kick_on_terminal();
        int evts = 0, high = 0;
        bit ok;
        kick();
        for (int i = 0; i < 8 * FRAME * 4 && evts < 7; i++) begin
            @(negedge clk_main);
            if (is_evt(m_n)) evts++;
        end
        step_until_evt_next(ok);
        checks++;
        if (!ok || evts != 7) begin
            errors++;
            $display("FAIL term_wait: got ok=%b vblanks=%0d expected ok=1 vblanks=7", ok, evts);
        end
        kick();
        for (int i = 0; i < WP + 8; i++) begin
            if (wdt_reset) high++;
            @(negedge clk_main);
        end
        checks++;
        if (high != 0) begin errors++; $display("FAIL wdt_kick_terminal: got high=%0d expected 0", high); end
    endtask

    task automatic test_async_reset();
        logic [27:0] got;
        bit ok;
        int high = 0;
        int16en = 1'b1;
        step_until_evt_next(ok);
        repeat (4 * HT + 1) @(negedge clk_main);
        checks++;
        if (!ok || oipl !== 1'b0 || vcount !== 9'(VVE + 1)) begin
            errors++;
            $display("FAIL async_setup: got ok=%b oipl=%b v=%0d expected ok=1 oipl=0 v=%0d",
                     ok, oipl, vcount, VVE + 1);
        end
        @(posedge clk_main);
        #2 reset = 1'b1;
        #1;
        got = {v6m, ce_6m, hcount, vcount, nhblk, nvblk, ncblk, nhsync, nvsync,
               video_sync, oipl, wdt_reset};
        checks++;
        if (got !== RST_VAL) begin
            errors++;
            $display("FAIL async_reset_state: got %h expected %h", got, RST_VAL);
        end
        int16en = 1'b0;
        @(negedge clk_main);
        reset = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 9 * FRAME * 4; i++) begin
            @(negedge clk_main);
            if (wdt_reset) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL async_wdt_wait: got no pulse expected pulse"); end
        repeat (3) @(negedge clk_main);
        @(posedge clk_main);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (wdt_reset !== 1'b0) begin errors++; $display("FAIL async_wdt_abort: got %b expected 0", wdt_reset); end
        @(negedge clk_main);
        reset = 1'b0;
        for (int i = 0; i < WP + 4; i++) begin
            if (wdt_reset) high++;
            @(negedge clk_main);
        end
        checks++;
        if (high != 0) begin errors++; $display("FAIL async_wdt_resume: got high=%0d expected 0", high); end
    endtask

    initial begin
        test_reset();
        test_release();
        test_decode();
        test_irq();
        test_irq_collision();
        test_random();
        test_watchdog();
        test_kick_every7();
        test_kick_on_terminal();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
